// File: rtl/ram_512.sv
// 512 x 16 random-access memory: synchronous write on load, combinational read.
// Optional macro RAM512_WRITE_THROUGH_EN forwards the write data to out while load is high.
module ram_512 #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WIDTH-1:0]  out,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load
);

  // Plain storage with no handshake: a write is accepted on every rising
  // edge where load is high and reset is released; reads never stall.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;

  // The whole array is held in flops so the asynchronous clear reaches every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[addr] <= in;
    end
  end

  assign rd_word = mem[addr];

  always_comb begin
    out = rd_word;
    if (!rst_n) begin
      out = '0;
    end
`ifdef RAM512_WRITE_THROUGH_EN
    else if (load) begin
      out = in;
    end
`endif
  end

endmodule

// File: tb/tb_ram_512.sv
// Self-checking bench for ram_512 against an array-based reference model.
module tb_ram_512;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  out;
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] addr;
  logic              load;

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  ram_512 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .out  (out),
    .in   (in),
    .addr (addr),
    .load (load)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and drivers
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    addr = a;
    in   = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (rst_n) model[a] = d;
  endtask

  task automatic test_reset();
    addr  = '0;
    in    = '0;
    load  = 1'b0;
    rst_n = 1'b0;
    #12;
    model_clear();
    for (int a = 0; a < 4; a++) begin
      addr = ADDR_W'(a * 170);
      #1;
      tests_run++;
      if (out !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_held addr=%h: got %h expected 0000", addr, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      addr = ADDR_W'(a);
      #1;
      tests_run++;
      if (out !== model[a]) begin
        tests_failed++;
        $display("FAIL reset_sweep addr=%h: got %h expected %h", addr, out, model[a]);
      end
    end
  endtask

  task automatic test_write_readback();
    logic [ADDR_W-1:0] addrs [9];
    logic [WIDTH-1:0]  datas [9];
    addrs = '{9'h000, 9'h001, 9'h002, 9'h013, 9'h00C, 9'h055, 9'h006, 9'h1A7, 9'h1FF};
    datas = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd1};
    for (int i = 0; i < 9; i++) do_write(addrs[i], datas[i]);
    for (int i = 0; i < 9; i++) exp_q.push_back(datas[i]);
    for (int i = 0; i < 9; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      addr = addrs[i];
      #1;
      tests_run++;
      if (out !== e) begin
        tests_failed++;
        $display("FAIL readback addr=%h: got %h expected %h", addr, out, e);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    addr = 9'h000;
    in   = 16'hFFFF;
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (out !== 16'd2) begin
        tests_failed++;
        $display("FAIL hold edge=%0d: got %h expected 0002", i, out);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [ADDR_W-1:0] probe [3];
    probe = '{9'h013, 9'h012, 9'h1FF};
    do_write(9'h013, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      addr = probe[i];
      #1;
      tests_run++;
      if (out !== model[probe[i]]) begin
        tests_failed++;
        $display("FAIL overwrite addr=%h: got %h expected %h", addr, out, model[probe[i]]);
      end
    end
    tests_run++;
    if (model[9'h013] !== 16'hABCD || out !== 16'd1) begin
      tests_failed++;
      $display("FAIL overwrite_const: got %h at 1ff expected 0001", out);
    end
  endtask

  task automatic test_write_visibility();
    logic [WIDTH-1:0] old_v;
    logic [WIDTH-1:0] new_v;
    @(negedge clk);
    addr  = 9'h055;
    old_v = model[9'h055];
    new_v = 16'h5A5A;
    in    = new_v;
    load  = 1'b1;
    #1;
    tests_run++;
`ifdef RAM512_WRITE_THROUGH_EN
    if (out !== new_v) begin
`else
    if (out !== old_v) begin
`endif
      tests_failed++;
      $display("FAIL visibility_before_edge: got %h old %h new %h", out, old_v, new_v);
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    model[9'h055] = new_v;
    #1;
    tests_run++;
    if (out !== new_v) begin
      tests_failed++;
      $display("FAIL visibility_after_edge: got %h expected %h", out, new_v);
    end
  endtask

  task automatic test_comb_read();
    @(negedge clk);
    load = 1'b0;
    addr = 9'h000;
    #1;
    tests_run++;
    if (out !== 16'd2) begin
      tests_failed++;
      $display("FAIL comb_read addr=000: got %h expected 0002", out);
    end
    addr = 9'h1FF;
    #1;
    tests_run++;
    if (out !== 16'd1) begin
      tests_failed++;
      $display("FAIL comb_read addr=1ff: got %h expected 0001", out);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    addr = 9'h1A7;
    #1;
    tests_run++;
    if (out !== model[9'h1A7]) begin
      tests_failed++;
      $display("FAIL pre_reset addr=1a7: got %h expected %h", out, model[9'h1A7]);
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    tests_run++;
    if (out !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_reset addr=1a7: got %h expected 0000", out);
    end
    // A write attempted while reset is held must not land.
    in   = 16'h5555;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (out !== 16'd0) begin
      tests_failed++;
      $display("FAIL write_blocked addr=1a7: got %h expected 0000", out);
    end
    for (int i = 0; i < 16; i++) begin
      addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      #1;
      tests_run++;
      if (out !== 16'd0) begin
        tests_failed++;
        $display("FAIL post_reset addr=%h: got %h expected 0000", addr, out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      a = (i % 7 == 0) ? ADDR_W'((i % 14 == 0) ? 0 : DEPTH - 1)
                       : ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 9) < 5) begin
        do_write(a, WIDTH'($urandom));
      end else begin
        @(negedge clk);
        addr = a;
        in   = WIDTH'($urandom);
        load = 1'b0;
        #1;
        tests_run++;
        if (out !== model[a]) begin
          tests_failed++;
          $display("FAIL random_read addr=%h: got %h expected %h", a, out, model[a]);
        end
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      addr = ADDR_W'(a);
      #1;
      tests_run++;
      if (out !== model[a]) begin
        tests_failed++;
        $display("FAIL final_sweep addr=%h: got %h expected %h", addr, out, model[a]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_write_readback();
    test_hold();
    test_overwrite();
    test_comb_read();
    test_write_visibility();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
